// File: rtl/vedic_mac_accum.sv
// Saturating multiply-accumulate back end for the 3-bit Vedic multiplier product stream.
// Sums products per frame and holds one registered result until the consumer takes it.
module vedic_mac_accum #(
   parameter int unsigned PROD_W    = 6,
   parameter int unsigned ACC_W     = 12,
   parameter int unsigned MAX_TERMS = 64,
   localparam int unsigned CNT_W    = $clog2(MAX_TERMS + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PROD_W-1:0] prod,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic [CNT_W-1:0]  term_count,
   output logic              overflow,
   output logic              out_valid,
   input  logic              out_ready
);

   typedef enum logic [0:0] {StAccum, StHold} state_e;

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MAX_TERMS - 1);

   state_e           st_q, st_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [ACC_W-1:0] acc_out_q, acc_out_d;
   logic [CNT_W-1:0] term_q, term_d;
   logic             ovf_out_q, ovf_out_d;

   logic [ACC_W:0]   sum;
   logic [ACC_W-1:0] acc_sat;

   // One extra bit of headroom: the carry out is the saturation flag.
   assign sum     = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
   assign acc_sat = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

   always_comb begin
      st_d      = st_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      acc_out_d = acc_out_q;
      term_d    = term_q;
      ovf_out_d = ovf_out_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (st_q)
         StAccum: begin
            in_ready = 1'b1;
            if (in_valid) begin
               acc_d = acc_sat;
               cnt_d = cnt_q + CNT_W'(1);
               ovf_d = ovf_q | sum[ACC_W];
               if (in_last || (cnt_q == LastCnt)) begin
                  st_d      = StHold;
                  acc_out_d = acc_d;
                  term_d    = cnt_d;
                  ovf_out_d = ovf_d;
               end
            end
         end
         StHold: begin
            out_valid = 1'b1;
            // Release clears the running frame; next beat is taken a cycle later.
            if (out_ready) begin
               st_d  = StAccum;
               acc_d = '0;
               cnt_d = '0;
               ovf_d = 1'b0;
            end
         end
         default: st_d = StAccum;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q      <= StAccum;
         acc_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         acc_out_q <= '0;
         term_q    <= '0;
         ovf_out_q <= 1'b0;
      end else begin
         st_q      <= st_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         acc_out_q <= acc_out_d;
         term_q    <= term_d;
         ovf_out_q <= ovf_out_d;
      end
   end

   assign acc_out    = acc_out_q;
   assign term_count = term_q;
   assign overflow   = ovf_out_q;

endmodule

// File: tb/tb_vedic_mac_accum.sv
// Directed bench for vedic_mac_accum: a 12-bit and a 6-bit accumulator instance,
// expected frame results queued as beats are accepted and popped on each output handshake.
module tb_vedic_mac_accum;

   localparam int MaxT = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] prod [2];
   logic       in_valid [2];
   logic       in_last [2];
   logic       out_ready [2];
   logic       in_ready [2];
   logic       out_valid [2];
   logic       overflow [2];
   logic [6:0] term_count [2];
   logic [11:0] acc12;
   logic [5:0]  acc6;

   always #5 clk = ~clk;

   vedic_mac_accum #(.PROD_W(6), .ACC_W(12), .MAX_TERMS(MaxT)) u_dut12 (
      .clk        (clk),
      .rst_n      (rst_n),
      .prod       (prod[0]),
      .in_valid   (in_valid[0]),
      .in_last    (in_last[0]),
      .in_ready   (in_ready[0]),
      .acc_out    (acc12),
      .term_count (term_count[0]),
      .overflow   (overflow[0]),
      .out_valid  (out_valid[0]),
      .out_ready  (out_ready[0])
   );

   vedic_mac_accum #(.PROD_W(6), .ACC_W(6), .MAX_TERMS(MaxT)) u_dut6 (
      .clk        (clk),
      .rst_n      (rst_n),
      .prod       (prod[1]),
      .in_valid   (in_valid[1]),
      .in_last    (in_last[1]),
      .in_ready   (in_ready[1]),
      .acc_out    (acc6),
      .term_count (term_count[1]),
      .overflow   (overflow[1]),
      .out_valid  (out_valid[1]),
      .out_ready  (out_ready[1])
   );

   typedef struct packed {
      logic [11:0] acc;
      logic [6:0]  cnt;
      logic        ovf;
   } res_t;

   res_t sb [$];
   int   n_vec = 0;
   int   n_err = 0;
   int   last_wait = 0;
   int   m_acc = 0;
   int   m_cnt = 0;
   logic m_ovf = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] acc_of(input int s);
      return (s != 0) ? {6'b0, acc6} : acc12;
   endfunction

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Called one step after a rising edge; returns one step after the accepting edge.
   task automatic beat(input int s, input logic [5:0] p, input logic l);
      int maxv;
      int n;
      maxv = (s != 0) ? 63 : 4095;
      n = 0;
      prod[s]     = p;
      in_valid[s] = 1'b1;
      in_last[s]  = l;
      @(negedge clk);
      while (!in_ready[s] && n < 200) begin
         @(negedge clk);
         n++;
      end
      last_wait = n;
      if (n >= 200) chk("beat_accept_timeout", in_ready[s], 1);
      sync();
      in_valid[s] = 1'b0;
      in_last[s]  = 1'b0;
      prod[s]     = '0;
      m_acc = m_acc + int'(p);
      if (m_acc > maxv) begin
         m_acc = maxv;
         m_ovf = 1'b1;
      end
      m_cnt++;
      if (l || m_cnt == MaxT) begin
         sb.push_back({12'(m_acc), 7'(m_cnt), m_ovf});
         m_acc = 0;
         m_cnt = 0;
         m_ovf = 1'b0;
      end
   endtask

   task automatic collect(input int s, input string tag);
      res_t e;
      int   n;
      n = 0;
      while (!out_valid[s] && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_out_valid"}, out_valid[s], 1);
      chk({tag, "_sb_pending"}, (sb.size() != 0), 1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_acc_out"}, acc_of(s), e.acc);
         chk({tag, "_term_count"}, term_count[s], e.cnt);
         chk({tag, "_overflow"}, overflow[s], e.ovf);
      end
      out_ready[s] = 1'b1;
      sync();
      out_ready[s] = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         prod[i] = '0;
         in_valid[i] = 1'b0;
         in_last[i] = 1'b0;
         out_ready[i] = 1'b0;
      end
      #12;
      for (int i = 0; i < 2; i++) begin
         chk("rst_out_valid", out_valid[i], 0);
         chk("rst_in_ready", in_ready[i], 1);
         chk("rst_acc_out", acc_of(i), 0);
         chk("rst_term_count", term_count[i], 0);
         chk("rst_overflow", overflow[i], 0);
      end
      rst_n = 1'b1;
      sync();

      // Dot product of multiplier vectors 1x2 2x4 4x5 5x6 6x7.
      beat(0, 6'd2, 1'b0);
      beat(0, 6'd8, 1'b0);
      beat(0, 6'd20, 1'b0);
      beat(0, 6'd30, 1'b0);
      beat(0, 6'd42, 1'b1);
      @(negedge clk);
      chk("t1_latency_out_valid", out_valid[0], 1);
      chk("t1_hold_in_ready", in_ready[0], 0);
      collect(0, "t1");
      @(negedge clk);
      chk("t1_release_in_ready", in_ready[0], 1);
      chk("t1_release_out_valid", out_valid[0], 0);
      sync();

      // Saturation on the 6-bit instance, then a clean frame.
      beat(1, 6'd42, 1'b0);
      beat(1, 6'd42, 1'b1);
      collect(1, "t2_sat");
      beat(1, 6'd5, 1'b1);
      collect(1, "t2_clean");

      // Auto-close on the 64th beat.
      for (int i = 0; i < MaxT; i++) beat(0, 6'd1, 1'b0);
      @(negedge clk);
      chk("t3_auto_close_valid", out_valid[0], 1);
      chk("t3_hold_in_ready", in_ready[0], 0);
      collect(0, "t3");

      // Backpressure with an upstream beat waiting.
      beat(0, 6'd2, 1'b0);
      beat(0, 6'd8, 1'b0);
      beat(0, 6'd20, 1'b1);
      prod[0] = 6'd9;
      in_valid[0] = 1'b1;
      in_last[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_bp_in_ready", in_ready[0], 0);
         chk("t4_bp_acc_out", acc12, 30);
         chk("t4_bp_term_count", term_count[0], 3);
      end
      collect(0, "t4_held");
      beat(0, 6'd9, 1'b1);
      chk("t4_held_beat_wait", last_wait, 0);
      collect(0, "t4_next");

      // Bubble carrying in_last and junk prod must be ignored.
      beat(0, 6'd7, 1'b0);
      prod[0] = 6'd63;
      in_last[0] = 1'b1;
      in_valid[0] = 1'b0;
      sync();
      prod[0] = '0;
      in_last[0] = 1'b0;
      beat(0, 6'd7, 1'b1);
      collect(0, "t5");

      // Reset mid-frame discards the partial sum.
      beat(0, 6'd10, 1'b0);
      beat(0, 6'd10, 1'b0);
      beat(0, 6'd10, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_out_valid", out_valid[0], 0);
      chk("t6_rst_in_ready", in_ready[0], 1);
      chk("t6_rst_term_count", term_count[0], 0);
      chk("t6_rst_acc_out", acc12, 0);
      m_acc = 0;
      m_cnt = 0;
      m_ovf = 1'b0;
      #2;
      rst_n = 1'b1;
      sync();
      beat(0, 6'd20, 1'b1);
      collect(0, "t6");

      chk("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/vedic_mac_accum.md
Name: vedic_mac_accum

Overview:
- Sequential multiply-accumulate back end that sits directly downstream of the 3-bit Vedic multiplier.
- Consumes its 6-bit product stream through a valid/ready handshake and sums products into a saturating accumulator.
- Presents one registered dot-product result per frame, delimited by in_last or by a maximum term count.
- Holds the result until the consumer accepts it.

Parameters:
- PROD_W, 6: width of the incoming product (matches 3x3 Vedic multiplier output).
- ACC_W, 12: accumulator/result width; must be >= PROD_W.
- MAX_TERMS, 64: maximum products per frame; the frame closes automatically on the MAX_TERMS-th accepted beat.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- prod  input  PROD_W  unsigned product from the Vedic multiplier.
- in_valid  input  1  prod/in_last are valid this cycle.
- in_last  input  1  this beat is the final term of the frame.
- in_ready  output  1  block accepts a beat this cycle.
- acc_out  output  ACC_W  frame result; valid while out_valid=1.
- term_count  output  $clog2(MAX_TERMS+1)  number of terms summed into acc_out.
- overflow  output  1  sticky: saturation occurred in this frame.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.

Behaviour:
- Reset (async assert, sync-release use assumed by caller): state=ACCUM, accumulator=0, acc_out=0, term_count=0, overflow=0, out_valid=0, in_ready=1. Reset mid-frame discards the partial sum; no result is emitted for that frame.
- Two states, ACCUM and HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - A beat is accepted iff in_valid && in_ready.
  - On each accepted beat: acc <= sat(acc + prod) and count <= count+1.
  - sat: if the true sum >= 2^ACC_W, acc <= 2^ACC_W-1 and overflow <= 1. overflow stays set until the frame is released.
  - Frame close: the accepted beat has in_last=1, or it is the MAX_TERMS-th beat (count == MAX_TERMS-1 before the update). Go to HOLD; acc_out/term_count/overflow register that beat's updated values.
  - in_last on a beat with in_valid=0 is ignored. prod/in_last are don't-care when in_valid=0.
- HOLD:
  - out_valid=1, in_ready=0. acc_out, term_count and overflow are held stable.
  - in_valid is ignored; the upstream must hold its beat.
  - On out_ready=1, the result is consumed that cycle. Next cycle: state=ACCUM, accumulator=0, count=0, overflow=0, out_valid=0, in_ready=1. No same-cycle bypass: the first beat of the next frame is accepted no earlier than the cycle after release.
- Latency:
  - Result visible (out_valid=1) on the cycle after the closing beat is accepted.
  - Minimum frame-to-frame throughput is N+1 cycles for N terms, plus handshake wait.
- Width rules:
  - prod is zero-extended to ACC_W+1 for the add; the saturation test uses the carry bit.
  - term_count is never 0 in HOLD and never exceeds MAX_TERMS.
- Single-term frame (in_last on the first beat): acc_out=prod, term_count=1.
- acc_out/term_count/overflow outputs read 0 after reset, then retain the last released frame's values while in ACCUM (don't-care when out_valid=0).

Test Plan:
- Multiplier vectors 1x2, 2x4, 4x5, 5x6, 6x7 (prod 2, 8, 20, 30, 42), in_last on the 5th, out_ready=1 -> out_valid one cycle after the 5th beat, acc_out=102, term_count=5, overflow=0, in_ready=1 the following cycle.
- ACC_W=6, prod 42 then 42 with in_last -> acc_out=63, overflow=1, term_count=2. Next frame prod 5 with in_last -> acc_out=5, overflow=0.
- 64 beats of prod=1 with in_last never asserted -> frame auto-closes on beat 64: acc_out=64, term_count=64, in_ready=0 during HOLD.
- Backpressure: close a frame with sum 30, hold out_ready=0 for 3 cycles while in_valid=1 -> acc_out stays 30, in_ready=0, no beats counted. Raise out_ready -> release; the held beat is accepted the cycle after.
- Gaps: prod 7, bubble (in_valid=0, in_last=1, prod=63), prod 7 with in_last -> acc_out=14, term_count=2.
- Assert rst_n low mid-frame after 3 beats (sum 30) -> immediately out_valid=0, in_ready=1, term_count=0. After release, frame prod 20 with in_last -> acc_out=20, term_count=1.
